// File: rtl/pam4_symbol_upsampler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pam4_symbol_upsampler_if : valid/ready symbol handshake into the upsampler
// Revision : 1.0
// ---------------------------------------------------------------------------
interface pam4_symbol_upsampler_if;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym_data;

    modport master (
        output sym_valid,
        output sym_data,
        input  sym_ready
    );

    modport slave (
        input  sym_valid,
        input  sym_data,
        output sym_ready
    );
endinterface
`default_nettype wire

// File: rtl/pam4_symbol_upsampler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pam4_symbol_upsampler : buffered Gray PAM-4 mapper with OSR zero-stuffing
// Revision : 1.0
// ---------------------------------------------------------------------------
module pam4_symbol_upsampler #(
    parameter int WIDTH      = 7,
    parameter int OSR        = 4,
    parameter int LVL_A      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int START_LVL  = 2
) (
    input  wire logic                    clk,
    input  wire logic                    rstn,
    input  wire logic                    en,
    pam4_symbol_upsampler_if.slave       sym,
    output logic signed [WIDTH-1:0]      data_out,
    output logic                         sym_strobe,
    output logic                         underflow,
    input  wire logic                    underflow_clr
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PH_W = $clog2(OSR);

    localparam logic [PH_W-1:0]         PH_LAST    = PH_W'(OSR - 1);
    localparam logic [AW:0]             FILL_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]             FILL_START = (AW + 1)'(START_LVL);
    localparam logic signed [WIDTH-1:0] LVL_IN     = WIDTH'(LVL_A);
    localparam logic signed [WIDTH-1:0] LVL_OUT    = WIDTH'(3 * LVL_A);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fill;
    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_nxt;

    logic            full;
    logic            empty;
    logic            slot;
    logic            do_push;
    logic            do_pop;
    logic            uf_set;

    // Gray order: 00 -> -3A, 01 -> -A, 11 -> +A, 10 -> +3A
    function automatic logic signed [WIDTH-1:0] pam4_map(input logic [1:0] s);
        logic signed [WIDTH-1:0] lvl;
        case (s)
            2'b00:   lvl = -LVL_OUT;
            2'b01:   lvl = -LVL_IN;
            2'b11:   lvl = LVL_IN;
            default: lvl = LVL_OUT;
        endcase
        return lvl;
    endfunction

    assign full          = (fill == FILL_FULL);
    assign empty         = (fill == '0);
    assign sym.sym_ready = (state != ST_IDLE) && !full;

    // en low overrides everything at the edge: no push, pop or underflow, just flush
    assign slot    = (state == ST_RUN) && (ph == '0);
    assign do_push = en && sym.sym_valid && sym.sym_ready;
    assign do_pop  = en && slot && !empty;
    assign uf_set  = en && slot && empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ph_nxt    = '0;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_PRIME;
                end
                ST_PRIME: begin
                    if (fill >= FILL_START) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    ph_nxt = (ph == PH_LAST) ? '0 : ph + 1'b1;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph <= '0;
        end else begin
            ph <= ph_nxt;
        end
    end

    // Storage needs no reset: fill/pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= sym.sym_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (!en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out   <= '0;
            sym_strobe <= 1'b0;
        end else begin
            data_out   <= do_pop ? pam4_map(mem[rd_ptr]) : '0;
            sym_strobe <= do_pop;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underflow <= 1'b0;
        end else if (uf_set) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pam4_symbol_upsampler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pam4_symbol_upsampler : directed + randomized bench against a queue model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_pam4_symbol_upsampler;

    localparam int WIDTH = 7;
    localparam int OSR   = 4;
    localparam int LVL_A = 16;
    localparam int DEPTH = 4;
    localparam int START = 2;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic en    = 1'b0;
    logic clr   = 1'b0;
    logic en2   = 1'b0;
    logic clr2  = 1'b0;

    logic signed [WIDTH-1:0] data_out;
    logic                    strobe;
    logic                    uflow;
    logic signed [WIDTH-1:0] data_out2;
    logic                    strobe2;
    logic                    uflow2;

    always #5 clk = ~clk;

    pam4_symbol_upsampler_if sif ();
    pam4_symbol_upsampler_if sif2 ();

    pam4_symbol_upsampler #(
        .WIDTH(WIDTH), .OSR(OSR), .LVL_A(LVL_A), .FIFO_DEPTH(DEPTH), .START_LVL(START)
    ) u_dut (
        .clk(clk), .rstn(rstn), .en(en), .sym(sif.slave),
        .data_out(data_out), .sym_strobe(strobe), .underflow(uflow), .underflow_clr(clr)
    );

    pam4_symbol_upsampler #(
        .WIDTH(7), .OSR(2), .LVL_A(20), .FIFO_DEPTH(4), .START_LVL(2)
    ) u_dut2 (
        .clk(clk), .rstn(rstn), .en(en2), .sym(sif2.slave),
        .data_out(data_out2), .sym_strobe(strobe2), .underflow(uflow2), .underflow_clr(clr2)
    );

    // Reference model: symbol queue plus a count of cycles spent running
    int         m_mode;
    logic [1:0] m_q[$];
    int         m_cnt;
    bit         m_uf;
    integer     m_out;
    bit         m_stb;
    bit         m_rdy;

    int     n_vec = 0;
    int     n_err = 0;
    int     n_acc = 0;
    int     n_stb = 0;
    bit     capture = 0;
    integer trace[$];

    function automatic int lvl(input logic [1:0] s);
        case (s)
            2'b00:   return -3 * LVL_A;
            2'b01:   return -LVL_A;
            2'b11:   return LVL_A;
            default: return 3 * LVL_A;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_q.delete(); m_cnt = 0; m_uf = 0;
        m_out = 0; m_stb = 0; m_rdy = 0;
    endtask

    task automatic model_edge();
        bit rdy_pre, acc, set;
        int sz_pre;
        rdy_pre = (m_mode != 0) && (m_q.size() < DEPTH);
        sz_pre  = m_q.size();
        acc     = sif.sym_valid && rdy_pre;
        set     = 0;
        m_out   = 0;
        m_stb   = 0;
        if (!en) begin
            m_mode = 0; m_q.delete(); m_cnt = 0;
            if (clr) m_uf = 0;
        end else begin
            if (m_mode == 2) begin
                if (m_cnt % OSR == 0) begin
                    if (sz_pre > 0) begin
                        m_out = lvl(m_q.pop_front());
                        m_stb = 1;
                    end else begin
                        set = 1;
                    end
                end
                m_cnt++;
            end
            if (acc) begin
                m_q.push_back(sif.sym_data);
                n_acc++;
            end
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1 && sz_pre >= START) begin
                m_mode = 2;
                m_cnt  = 0;
            end
            if (set) m_uf = 1;
            else if (clr) m_uf = 0;
        end
        m_rdy = (m_mode != 0) && (m_q.size() < DEPTH);
    endtask

    task automatic chk(input string tag, input integer obs, input integer exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_out", data_out, m_out);
        chk("sym_strobe", strobe, m_stb);
        chk("underflow", uflow, m_uf);
        chk("sym_ready", sif.sym_ready, m_rdy);
    endtask

    task automatic step();
        @(posedge clk);
        if (rstn) model_edge();
        #1;
        check_all();
        if (strobe) n_stb++;
        if (capture) trace.push_back(data_out);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [1:0] s);
        bit took;
        took = 0;
        sif.sym_valid = 1'b1;
        sif.sym_data  = s;
        for (int i = 0; i < 40; i++) begin
            took = m_rdy && en;
            step();
            if (took) break;
        end
        sif.sym_valid = 1'b0;
        chk("push_accept", took, 1);
    endtask

    function automatic int first_nonzero();
        for (int i = 0; i < trace.size(); i++)
            if (trace[i] != 0) return i;
        return -1;
    endfunction

    integer     exp1[16] = '{-48, 0, 0, 0, -16, 0, 0, 0, 16, 0, 0, 0, 48, 0, 0, 0};
    logic [1:0] syms6[2] = '{2'b11, 2'b00};
    integer     exp6[4]  = '{20, 0, -60, 0};
    integer     t6[$];

    initial begin
        int fi, acc0, stb0, idx6;
        bit pre6;
        sif.sym_valid  = 1'b0;
        sif.sym_data   = 2'b00;
        sif2.sym_valid = 1'b0;
        sif2.sym_data  = 2'b00;
        model_reset();

        // Reset state
        #12;
        check_all();
        chk("rst_data_out2", data_out2, 0);
        chk("rst_ready2", sif2.sym_ready, 0);
        rstn = 1'b1;

        // 1: four back-to-back Gray symbols
        en = 1'b1;
        capture = 1;
        push(2'b00); push(2'b01); push(2'b11); push(2'b10);
        steps(20);
        capture = 0;
        fi = first_nonzero();
        chk("t1_first_found", (fi >= 0 && fi + 16 <= trace.size()) ? 1 : 0, 1);
        if (fi >= 0 && fi + 16 <= trace.size())
            for (int i = 0; i < 16; i++) chk("t1_seq", trace[fi + i], exp1[i]);

        // 2: underflow after drain, clear, clear vs new underflow
        chk("t2_uf_set", uflow, 1);
        push(2'b01);
        steps(6);
        clr = 1'b1; step(); clr = 1'b0;
        steps(3);
        clr = 1'b1; steps(8); clr = 1'b0;
        steps(4);

        // 3: backpressure with continuous valid
        acc0 = n_acc; stb0 = n_stb;
        sif.sym_valid = 1'b1; sif.sym_data = 2'b10;
        steps(40);
        sif.sym_valid = 1'b0;
        steps(30);
        chk("t3_count", n_stb - stb0, n_acc - acc0);

        // 4: en drop with symbols queued, then re-prime
        sif.sym_valid = 1'b1; sif.sym_data = 2'(unsigned'($urandom));
        steps(6);
        sif.sym_valid = 1'b0;
        en = 1'b0; steps(2);
        en = 1'b1;
        trace.delete(); capture = 1;
        push(2'b11); push(2'b01);
        steps(12);
        capture = 0;
        fi = first_nonzero();
        chk("t4_first_sym", (fi >= 0) ? trace[fi] : -999, 16);

        // 5: asynchronous reset between edges while running
        sif.sym_valid = 1'b1; sif.sym_data = 2'b00;
        steps(10);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rstn = 1'b1;
        steps(8);
        sif.sym_valid = 1'b0;
        steps(8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            sif.sym_valid = 1'($urandom_range(0, 1));
            sif.sym_data  = 2'($urandom_range(0, 3));
            clr           = ($urandom_range(0, 15) == 0);
            en            = ($urandom_range(0, 39) != 0);
            step();
        end
        sif.sym_valid = 1'b0; clr = 1'b0; en = 1'b0;
        step();

        // 6: OSR=2, LVL_A=20 instance
        en2 = 1'b1;
        idx6 = 0;
        for (int c = 0; c < 20; c++) begin
            pre6 = sif2.sym_ready;
            if (idx6 < 2) begin
                sif2.sym_valid = 1'b1;
                sif2.sym_data  = syms6[idx6];
            end else begin
                sif2.sym_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (sif2.sym_valid && pre6) idx6++;
            if (strobe2 || t6.size() > 0) t6.push_back(data_out2);
        end
        sif2.sym_valid = 1'b0;
        chk("t6_len", (t6.size() >= 4) ? 1 : 0, 1);
        if (t6.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t6_seq", t6[i], exp6[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
